mux4_reg: RTL and testbench
===========================

Name: mux4_reg

Overview:
- Registered 4:1 data selector for datapath steering.
- Two select bits pick one of four equal-width inputs. The chosen word is captured on the clock edge.
- A valid qualifier travels alongside the data, giving downstream logic a one-cycle-latency, qualified output.
- Used as a leaf primitive wherever a clocked 4-way select is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of y.
- RESET_VAL, 0, value loaded into y on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  data input 0, selected when {u,v}=2'b00.
- b  input  WIDTH  data input 1, selected when {u,v}=2'b01.
- c  input  WIDTH  data input 2, selected when {u,v}=2'b10.
- d  input  WIDTH  data input 3, selected when {u,v}=2'b11.
- u  input  1  select MSB ("select1").
- v  input  1  select LSB ("select2").
- in_valid  input  1  inputs and select are meaningful this cycle.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y was updated on the most recent edge from valid inputs.

Interface note: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Select encoding: sel = {u,v}.
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- Selection is pure combinational decode of sel. The result is registered.
- Latency: exactly 1 clk cycle from inputs to y.
- Reset: at a rising edge with rst=1, y <= RESET_VAL and y_valid <= 0. Reset overrides in_valid. Reset mid-stream discards the in-flight value.
- Rising edge, rst=0, in_valid=1: y <= selected input; y_valid <= 1.
- Rising edge, rst=0, in_valid=0: y holds its previous value; y_valid <= 0.
- No backpressure: a new valid word is accepted every cycle. Back-to-back valid cycles update y every cycle.
- X/Z on u or v: simulation yields X on y. No synthesis-specific handling is required.
- Data inputs other than the selected one have no effect on y.
- No internal state other than the y and y_valid registers, plus the optional parity register.

Optional Feature:
- Macro: MUX4_REG_PARITY_EN.
- Defined:
  - Adds output y_par (1 bit).
  - y_par is registered even parity of the selected word, so ^{y,y_par}=0.
  - y_par updates with the same timing and enable as y.
  - y_par resets to the even parity of RESET_VAL.
  - y_par holds when in_valid=0.
- Undefined: no y_par port and no parity logic; everything else is identical.

Decomposition:
- Package mux4_pkg:
  - localparam SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - typedef sel_t as logic [1:0].
- Sub-module mux4_comb (WIDTH): purely combinational 4:1 select on sel_t.
- mux4_reg instantiates mux4_comb and adds the y, y_valid and y_par registers.

Test Plan:
- WIDTH=1; hold rst=1 for 2 edges, then release -> y=0, y_valid=0.
- a=1,b=0,c=0,d=0,u=0,v=0,in_valid=1 -> after 1 edge y=1, y_valid=1.
- a=0,b=1,c=0,d=0,u=0,v=1 -> y=1. Then set b=0 with sel still 01 -> y=0, which proves b is the selected input.
- Cover the remaining two selects, one per cycle:
  - a=0,b=0,c=1,d=0,u=1,v=0 -> y=1.
  - a=0,b=0,c=0,d=1,u=1,v=1 -> y=1.
  - Repeat each with the one-hot moved to a non-selected input -> y=0.
- Valid qualifier: after y=1 is captured, drive in_valid=0 and change all inputs -> y stays 1, y_valid=0.
- Reset override: assert rst=1 together with in_valid=1 and a selected input of 1 -> y=RESET_VAL, y_valid=0. With MUX4_REG_PARITY_EN, WIDTH=8, select 8'hA7 -> y_par=1.

Source files
------------

// File: rtl/mux4_pkg.sv
// -----------------------------------------------------------------------------
// mux4_pkg
// Shared select encoding for the registered 4:1 selector (mux4_reg) and its
// combinational core (mux4_comb).
//
// Contents:
//   sel_t              2-bit select word, formed as {u, v}
//   SEL_A..SEL_D       select codes for data inputs a..d
// -----------------------------------------------------------------------------
package mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage : mux4_pkg

// File: rtl/mux4_comb.sv
// -----------------------------------------------------------------------------
// mux4_comb
// Purely combinational 4:1 word select driven by a sel_t code.
//
// Parameters:
//   WIDTH   bit width of each data input and of the output
//
// Ports:
//   sel     input  sel_t     select code (SEL_A..SEL_D)
//   a..d    input  [WIDTH]   data inputs 0..3
//   y       output [WIDTH]   selected word
// -----------------------------------------------------------------------------
module mux4_comb
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: every always_comb output gets a default before the case so no
        // path leaves it unassigned; an unassigned path would infer a latch.
        y = '0;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            // Only reachable with X/Z on the select; propagate X so an
            // undriven select is visible in simulation.
            default: y = {WIDTH{1'bx}};
        endcase
    end

endmodule : mux4_comb

// File: rtl/mux4_reg.sv
// -----------------------------------------------------------------------------
// mux4_reg
// Registered 4:1 data selector with a valid qualifier. The word picked by
// {u, v} is captured on the rising edge of clk when in_valid is high; y_valid
// marks that y was refreshed on the most recent edge. Latency is one cycle,
// with no backpressure.
//
// Optional feature (macro MUX4_REG_PARITY_EN):
//   adds output y_par, the registered even parity of the selected word, so
//   that ^{y, y_par} == 0. Same enable and timing as y.
//
// Parameters:
//   WIDTH      bit width of each data input and of y
//   RESET_VAL  value loaded into y on reset
//
// Ports:
//   clk       input   rising-edge clock
//   rst       input   synchronous reset, active-high
//   a..d      input   [WIDTH] data inputs, selected by {u,v} = 00..11
//   u         input   select MSB
//   v         input   select LSB
//   in_valid  input   inputs and select are meaningful this cycle
//   y         output  [WIDTH] registered selected data
//   y_valid   output  y was updated on the most recent edge
//   y_par     output  registered even parity of y (MUX4_REG_PARITY_EN only)
// -----------------------------------------------------------------------------
module mux4_reg
    import mux4_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             u,
    input  logic             v,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
`ifdef MUX4_REG_PARITY_EN
    ,
    output logic             y_par
`endif
);

    sel_t             w_sel;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    assign w_sel = {u, v};

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux4_comb (
        .sel (w_sel),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .y   (w_sel_data)
    );

    // y only loads on valid input; y_valid follows in_valid every edge so a
    // held y is reported as stale. Reset wins over in_valid and drops any
    // in-flight word.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            r_y       <= RESET_VAL;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_sel_data;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;

`ifdef MUX4_REG_PARITY_EN
    logic w_sel_par;
    logic r_y_par;

    // Even parity bit: XOR of the word, so the word plus this bit has an
    // even number of ones.
    assign w_sel_par = ^w_sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_par <= ^RESET_VAL;
        end else if (in_valid) begin
            r_y_par <= w_sel_par;
        end
    end

    assign y_par = r_y_par;
`endif

endmodule : mux4_reg

// File: tb/tb_mux4_reg.sv
// -----------------------------------------------------------------------------
// tb_mux4_reg
// Directed self-checking bench for mux4_reg (WIDTH=1, RESET_VAL=0). When
// MUX4_REG_PARITY_EN is defined, a second WIDTH=8 instance sharing the clock,
// reset, select and valid lines exercises the parity output.
// -----------------------------------------------------------------------------
module tb_mux4_reg;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic u, v;
    logic in_valid;
    logic y;
    logic y_valid;

    int n_compared;
    int n_mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX4_REG_PARITY_EN
    logic       y_par1;
    logic [7:0] a8, b8, c8, d8;
    logic [7:0] y8;
    logic       y8_valid;
    logic       y8_par;

    mux4_reg #(
        .WIDTH (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .u        (u),
        .v        (v),
        .in_valid (in_valid),
        .y        (y),
        .y_valid  (y_valid),
        .y_par    (y_par1)
    );

    mux4_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h3C)
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .a        (a8),
        .b        (b8),
        .c        (c8),
        .d        (d8),
        .u        (u),
        .v        (v),
        .in_valid (in_valid),
        .y        (y8),
        .y_valid  (y8_valid),
        .y_par    (y8_par)
    );
`else
    mux4_reg #(
        .WIDTH (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .u        (u),
        .v        (v),
        .in_valid (in_valid),
        .y        (y),
        .y_valid  (y_valid)
    );
`endif

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs; values settle before the next rising edge.
    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic id, input logic iu, input logic iv,
                         input logic ivalid);
        a        = ia;
        b        = ib;
        c        = ic;
        d        = id;
        u        = iu;
        v        = iv;
        in_valid = ivalid;
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MUX4_REG_PARITY_EN
        a8 = 8'h11; b8 = 8'h22; c8 = 8'hA7; d8 = 8'h44;
`endif
        #2;

        // Reset held for two edges.
        tick();
        tick();
        check("reset_y", {7'b0, y}, 8'h00);
        check("reset_y_valid", {7'b0, y_valid}, 8'h00);

        // Release with no valid input: still reset state.
        rst = 1'b0;
        tick();
        check("post_reset_y", {7'b0, y}, 8'h00);
        check("post_reset_y_valid", {7'b0, y_valid}, 8'h00);

        // sel=00 picks a.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("sel_a_y", {7'b0, y}, 8'h01);
        check("sel_a_y_valid", {7'b0, y_valid}, 8'h01);

        // sel=01 picks b, then b=0 proves it is b being selected.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("sel_b_one_y", {7'b0, y}, 8'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("sel_b_zero_y", {7'b0, y}, 8'h00);
        check("sel_b_zero_y_valid", {7'b0, y_valid}, 8'h01);

        // sel=10 picks c; sel=11 picks d.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("sel_c_one_y", {7'b0, y}, 8'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("sel_d_one_y", {7'b0, y}, 8'h01);

        // One-hot on a non-selected input must not reach y.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("sel_c_d_hot_y", {7'b0, y}, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("sel_d_c_hot_y", {7'b0, y}, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("sel_a_others_hot_y", {7'b0, y}, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("sel_b_others_hot_y", {7'b0, y}, 8'h00);

        // Capture y=1, then in_valid=0 with every input flipped: y holds.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("capture_y", {7'b0, y}, 8'h01);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("hold_y", {7'b0, y}, 8'h01);
        check("hold_y_valid", {7'b0, y_valid}, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold2_y", {7'b0, y}, 8'h01);
        check("hold2_y_valid", {7'b0, y_valid}, 8'h00);

        // Reset overrides a valid selected 1.
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("rst_override_y", {7'b0, y}, 8'h00);
        check("rst_override_y_valid", {7'b0, y_valid}, 8'h00);

        // Recovery: next valid edge captures normally.
        rst = 1'b0;
        tick();
        check("recover_y", {7'b0, y}, 8'h01);
        check("recover_y_valid", {7'b0, y_valid}, 8'h01);

`ifdef MUX4_REG_PARITY_EN
        check("w1_par_tracks_y", {7'b0, y_par1}, 8'h01);

        // Wide instance: reset value 3C has even weight -> parity 0.
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        check("p_reset_y", y8, 8'h3C);
        check("p_reset_par", {7'b0, y8_par}, 8'h00);
        rst = 1'b0;

        // Select c = A7 (five ones) -> parity 1.
        u = 1'b1; v = 1'b0; in_valid = 1'b1;
        tick();
        check("p_sel_c_y", y8, 8'hA7);
        check("p_sel_c_par", {7'b0, y8_par}, 8'h01);
        check("p_sel_c_y_valid", {7'b0, y8_valid}, 8'h01);

        // Select d = 44 (two ones) -> parity 0.
        u = 1'b1; v = 1'b1;
        tick();
        check("p_sel_d_y", y8, 8'h44);
        check("p_sel_d_par", {7'b0, y8_par}, 8'h00);

        // Hold with in_valid=0 after capturing A7.
        u = 1'b1; v = 1'b0;
        tick();
        in_valid = 1'b0;
        u = 1'b0; v = 1'b1;
        tick();
        check("p_hold_y", y8, 8'hA7);
        check("p_hold_par", {7'b0, y8_par}, 8'h01);

        // Reset with A7 selected and valid -> back to 3C / parity 0.
        rst = 1'b1;
        in_valid = 1'b1;
        u = 1'b1; v = 1'b0;
        tick();
        check("p_rst_override_y", y8, 8'h3C);
        check("p_rst_override_par", {7'b0, y8_par}, 8'h00);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_mux4_reg
